// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg -- shared types and defaults for the run controller.
//
// Contents:
//   PC_W_DEF, CNT_W_DEF : default program-counter and instruction-counter widths
//   runState_t          : controller state encoding (IDLE, LOAD, RUN, DONE)
package run_ctrl_pkg;

    localparam int PC_W_DEF  = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } runState_t;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// sat_counter -- W-bit up counter that sticks at all-ones.
//
// Ports:
//   CLK    in   clock, rising edge
//   Reset  in   asynchronous active-high reset, clears Count
//   Clear  in   synchronous clear (wins over Enable)
//   Enable in   increment by one this edge unless already at all-ones
//   Count  out  current count
//   AtMax  out  Count is all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         Clear,
    input  logic         Enable,
    output logic [W-1:0] Count,
    output logic         AtMax
);

    assign AtMax = &Count;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            Count <= '0;
        end else if (Clear) begin
            Count <= '0;
        end else if (Enable && !AtMax) begin
            Count <= Count + W'(1);
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl -- start/stop controller for a small core.
//
// A Start level moves the block to LOAD (PC load strobe with the captured
// entry address); releasing Start lets the core run. Every unstalled RUN
// cycle retires one instruction. The run ends on a retired Halt (Timeout=0)
// or on hitting the retire budget / counter saturation (Timeout=1). Done and
// Timeout are sticky until the next Start.
//
// Ports:
//   CLK         in   clock, rising edge
//   Reset       in   asynchronous active-high reset
//   Start       in   level, (re)start request; held high keeps LOAD
//   Start_Addr  in   entry address, captured on every edge with Start=1
//   Halt        in   halt decoded at current PC (used only on a RUN retire)
//   Stall       in   core stalled; no retire this cycle
//   Budget      in   retire limit, 0 = unlimited
//   Run         out  core enable (state RUN)
//   PCLoad      out  PC load strobe (state LOAD)
//   PCLoadAddr  out  captured Start_Addr
//   Done        out  run finished (sticky)
//   Timeout     out  run ended by budget/saturation rather than Halt
//   InstrCount  out  retired instructions of current/last run
//   StateDbg    out  current FSM state encoding
//
// All outputs come straight from registers; no input reaches an output
// combinationally.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter bit DONE_ON_SAT = 1'b1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  Start_Addr,
    input  logic             Halt,
    input  logic             Stall,
    input  logic [CNT_W-1:0] Budget,
    output logic             Run,
    output logic             PCLoad,
    output logic [PC_W-1:0]  PCLoadAddr,
    output logic             Done,
    output logic             Timeout,
    output logic [CNT_W-1:0] InstrCount,
    output logic [1:0]       StateDbg
);

    runState_t        state, stateNext;
    logic             doneReg, doneNext;
    logic             timeoutReg, timeoutNext;
    logic [PC_W-1:0]  addrReg, addrNext;
    logic             cntClear, cntEnable;
    logic             cntAtMax;
    logic [CNT_W-1:0] countNext;
    logic             budgetHit, satHit;

    sat_counter #(.W(CNT_W)) u_count (
        .CLK    (CLK),
        .Reset  (Reset),
        .Clear  (cntClear),
        .Enable (cntEnable),
        .Count  (InstrCount),
        .AtMax  (cntAtMax)
    );

    // Count value after this retire, already saturated, so the comparisons
    // below never see a wrapped value.
    assign countNext = cntAtMax ? InstrCount : InstrCount + CNT_W'(1);

    // "<=" covers both the exact hit and a budget lowered below the count.
    assign budgetHit = (Budget != '0) && (Budget <= countNext);
    assign satHit    = DONE_ON_SAT && (Budget == '0) && (&countNext);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            doneReg    <= 1'b0;
            timeoutReg <= 1'b0;
            addrReg    <= '0;
        end else begin
            state      <= stateNext;
            doneReg    <= doneNext;
            timeoutReg <= timeoutNext;
            addrReg    <= addrNext;
        end
    end

    always_comb begin
        stateNext   = state;
        doneNext    = doneReg;
        timeoutNext = timeoutReg;
        addrNext    = addrReg;
        cntClear    = 1'b0;
        cntEnable   = 1'b0;

        // Start overrides everything else at this edge, including a Halt or
        // budget hit that would otherwise end the run.
        if (Start) begin
            stateNext   = LOAD;
            doneNext    = 1'b0;
            timeoutNext = 1'b0;
            addrNext    = Start_Addr;
            cntClear    = 1'b1;
        end else begin
            case (state)
                IDLE: stateNext = IDLE;
                LOAD: stateNext = RUN;
                RUN: begin
                    if (!Stall) begin
                        cntEnable = 1'b1;
                        if (Halt) begin
                            stateNext   = DONE;
                            doneNext    = 1'b1;
                            timeoutNext = 1'b0;
                        end else if (budgetHit || satHit) begin
                            stateNext   = DONE;
                            doneNext    = 1'b1;
                            timeoutNext = 1'b1;
                        end
                    end
                end
                DONE:    stateNext = DONE;
                default: stateNext = IDLE;
            endcase
        end
    end

    assign Run        = (state == RUN);
    assign PCLoad     = (state == LOAD);
    assign PCLoadAddr = addrReg;
    assign Done       = doneReg;
    assign Timeout    = timeoutReg;
    assign StateDbg   = state;

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter PC_W, default 8, width of program-counter start/load address.
REQ-002 Parameter CNT_W, default 16, width of retired-instruction counter and budget.
REQ-003 Parameter DONE_ON_SAT, default 1, 1 = counter saturation ends the run with Timeout.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Start  input  1  level; high requests a (re)start; holding it high keeps the block in LOAD.
REQ-007 Start_Addr  input  PC_W  program entry address, sampled every edge while Start=1.
REQ-008 Halt  input  1  decoded halt instruction at current PC; meaningful only when Run=1.
REQ-009 Stall  input  1  core stalled this cycle; no instruction retires.
REQ-010 Budget  input  CNT_W  maximum retired instructions; 0 = unlimited; sampled on retire edges.
REQ-011 Run  output  1  core enable; high only in RUN.
REQ-012 PCLoad  output  1  PC load strobe; high only in LOAD.
REQ-013 PCLoadAddr  output  PC_W  captured Start_Addr, valid while PCLoad=1.
REQ-014 Done  output  1  program finished; sticky until next Start.
REQ-015 Timeout  output  1  finish was caused by budget or saturation, not Halt.
REQ-016 InstrCount  output  CNT_W  retired-instruction count of current/last run.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, RUN, DONE; all outputs decoded from registered state/flags (no combinational input-to-output path).
REQ-018 Start=1 at an edge in any state SHALL move to LOAD, clear InstrCount, Done, Timeout and capture Start_Addr.
REQ-019 LOAD with Start=0 at an edge SHALL move to RUN; LOAD always lasts >= 1 cycle with PCLoad=1.
REQ-020 In RUN, a retire occurs at an edge when Stall=0; retire SHALL increment InstrCount by 1, saturating at all-ones.
REQ-021 Retire with Halt=1 SHALL count the halt instruction, move to DONE, set Done=1, Timeout=0.
REQ-022 Retire with Halt=0, Budget!=0 and InstrCount+1==Budget SHALL move to DONE with Done=1, Timeout=1.
REQ-023 Halt and budget hit on the same retire SHALL give Timeout=0 (Halt wins).
REQ-024 With DONE_ON_SAT=1, Budget=0 and InstrCount+1 reaching all-ones SHALL end the run with Timeout=1; with DONE_ON_SAT=0 counter holds at all-ones and RUN continues.
REQ-025 Budget < InstrCount+1 on a retire (budget lowered mid-run) SHALL also end the run with Timeout=1.
REQ-026 Stall=1 SHALL freeze count and state, and suppress Halt/budget evaluation.
REQ-027 DONE SHALL hold Done=1, Run=0, InstrCount and Timeout until Start; IDLE likewise waits for Start.
REQ-028 Latency: Done and Run=0 visible in the cycle after the terminating retire edge; Run=1 in the cycle after the LOAD->RUN edge.
REQ-029 Start during RUN SHALL abort the run without setting Done (restart takes precedence over Halt/budget at that edge).

Reset
REQ-030 Reset=1 SHALL immediately force IDLE, Run=0, PCLoad=0, PCLoadAddr=0, Done=0, Timeout=0, InstrCount=0, independent of CLK.
REQ-031 Reset asserted mid-run SHALL discard the run; after release the block waits in IDLE for Start.
REQ-032 Reset has priority over Start at every edge.

Structure
REQ-033 Package run_ctrl_pkg SHALL hold the state enum (IDLE, LOAD, RUN, DONE) and default PC_W/CNT_W constants.
REQ-034 One sub-module sat_counter (parameter W; clear, enable, saturating increment, at_max flag) SHALL implement InstrCount.
REQ-035 Total RTL 120-400 lines; no memories; single clock domain.

Verification
REQ-036 Start=1 two cycles, Start_Addr=8'h20, then Halt on 5th retire, no stalls -> PCLoad=1 for 2 cycles with PCLoadAddr=8'h20, InstrCount=5, Done=1, Timeout=0.
REQ-037 Budget=3, no Halt, Stall=1 on every other cycle -> exactly 3 retires, Done=1, Timeout=1, InstrCount=3, stalled cycles do not count.
REQ-038 Budget=4, Halt on 4th retire -> Done=1, Timeout=0, InstrCount=4.
REQ-039 CNT_W=4, Budget=0, DONE_ON_SAT=1 -> Done=1, Timeout=1 at InstrCount=15; with DONE_ON_SAT=0 Run stays 1, InstrCount holds 15.
REQ-040 Reset pulse mid-run (asynchronous, between edges) -> all outputs 0 immediately; Start=1 then resumes normally from new Start_Addr.
REQ-041 Start=1 asserted in RUN at InstrCount=7 together with Halt -> LOAD, Done stays 0, InstrCount=0.
